branch_predictor: RTL and testbench

IF-stage dynamic branch predictor: a direct-mapped table of 2-bit saturating counters paired with a branch target buffer (BTB). It supplies a next-PC prediction for the fetch PC each cycle. It is trained by the EX stage with the resolved outcome from the branch comparator flags and decode, so it is the predicting end of the branch-resolution path.

---
 rtl/branch_predictor.sv | 92 +++++++++
 tb/tb_branch_predictor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped 2-bit saturating counters plus BTB.
// Lookup is purely combinational from the fetch PC; training comes from EX
// and lands on the next rising edge (no read-after-write bypass).
module branch_predictor #(
   parameter int ENTRIES    = 64,
   parameter int IDX_W      = $clog2(ENTRIES),
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] if_pc_i,
   output logic                  pred_taken_o,
   output logic                  pred_hit_o,
   output logic [DATA_WIDTH-1:0] pred_next_pc_o,
   input  logic                  ex_update_i,
   input  logic [DATA_WIDTH-1:0] ex_pc_i,
   input  logic                  ex_taken_i,
   input  logic                  ex_is_jump_i,
   input  logic [DATA_WIDTH-1:0] ex_target_i
);

   localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

   logic [ENTRIES-1:0]                 r_valid;
   logic [ENTRIES-1:0][TAG_W-1:0]      r_tag;
   logic [ENTRIES-1:0][DATA_WIDTH-1:0] r_target;
   logic [ENTRIES-1:0][1:0]            r_ctr;

   logic [IDX_W-1:0] w_if_idx;
   logic [TAG_W-1:0] w_if_tag;
   logic             w_if_hit;
   logic [IDX_W-1:0] w_ex_idx;
   logic [TAG_W-1:0] w_ex_tag;
   logic             w_ex_hit;
   logic             w_ex_taken;
   logic [1:0]       w_ex_ctr;
   logic [1:0]       w_ctr_inc;
   logic [1:0]       w_ctr_dec;
   logic             w_unused;

   // PC byte offset never affects indexing or tags
   assign w_unused = ^ex_pc_i[1:0];

   assign w_if_idx = if_pc_i[IDX_W+1:2];
   assign w_if_tag = if_pc_i[DATA_WIDTH-1:IDX_W+2];
   assign w_ex_idx = ex_pc_i[IDX_W+1:2];
   assign w_ex_tag = ex_pc_i[DATA_WIDTH-1:IDX_W+2];

   // Lookup; reset clears valid bits asynchronously so this misses while rst is held
   always_comb begin
      w_if_hit       = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
      pred_hit_o     = w_if_hit;
      pred_taken_o   = w_if_hit && r_ctr[w_if_idx][1];
      pred_next_pc_o = pred_taken_o ? r_target[w_if_idx] : (if_pc_i + DATA_WIDTH'(4));
   end

   // Training-side decode: a jump is always taken, even if the direction flag says otherwise
   always_comb begin
      w_ex_hit   = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
      w_ex_taken = ex_taken_i || ex_is_jump_i;
      w_ex_ctr   = r_ctr[w_ex_idx];
      w_ctr_inc  = (w_ex_ctr == 2'b11) ? 2'b11 : w_ex_ctr + 2'b01;
      w_ctr_dec  = (w_ex_ctr == 2'b00) ? 2'b00 : w_ex_ctr - 2'b01;
   end

   // Table update: counter training on hit, allocation on taken miss
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= 2'b01;
         end
      end else if (ex_update_i) begin
         if (w_ex_hit) begin
            if (w_ex_taken) begin
               r_ctr[w_ex_idx]    <= ex_is_jump_i ? 2'b11 : w_ctr_inc;
               r_target[w_ex_idx] <= ex_target_i;
            end else begin
               r_ctr[w_ex_idx]    <= w_ctr_dec;
            end
         end else if (w_ex_taken) begin
            r_valid[w_ex_idx]  <= 1'b1;
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= ex_target_i;
            r_ctr[w_ex_idx]    <= ex_is_jump_i ? 2'b11 : 2'b10;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a behavioural table model predicts
// each cycle's lookup result before the edge and trains afterwards.
module tb_branch_predictor;

   localparam int ENT = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] if_pc_i = 32'h100;
   logic        pred_taken_o, pred_hit_o;
   logic [31:0] pred_next_pc_o;
   logic        ex_update_i = 1'b0;
   logic [31:0] ex_pc_i = '0;
   logic        ex_taken_i = 1'b0;
   logic        ex_is_jump_i = 1'b0;
   logic [31:0] ex_target_i = '0;

   branch_predictor dut (
      .clk(clk), .rst(rst), .if_pc_i(if_pc_i),
      .pred_taken_o(pred_taken_o), .pred_hit_o(pred_hit_o), .pred_next_pc_o(pred_next_pc_o),
      .ex_update_i(ex_update_i), .ex_pc_i(ex_pc_i), .ex_taken_i(ex_taken_i),
      .ex_is_jump_i(ex_is_jump_i), .ex_target_i(ex_target_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        taken;
      logic        hit;
      logic [31:0] nxt;
   } exp_t;

   exp_t        sb_q[$];
   int          n_chk = 0;
   int          n_fail = 0;

   logic        m_valid[ENT];
   logic [31:0] m_tag[ENT];
   logic [31:0] m_tgt[ENT];
   int          m_ctr[ENT];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < ENT; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
      end
   endtask

   function automatic exp_t m_look(input logic [31:0] pc);
      exp_t e;
      int   k;
      k       = int'((pc >> 2) % ENT);
      e.pc    = pc;
      e.hit   = m_valid[k] && (m_tag[k] == (pc >> ($clog2(ENT) + 2)));
      e.taken = e.hit && (m_ctr[k] >= 2);
      e.nxt   = e.taken ? m_tgt[k] : pc + 32'd4;
      return e;
   endfunction

   task automatic m_train(input logic [31:0] pc, input logic tk, input logic jp, input logic [31:0] tgt);
      int   k;
      logic t;
      exp_t e;
      k = int'((pc >> 2) % ENT);
      t = tk | jp;
      e = m_look(pc);
      if (e.hit) begin
         if (t) begin
            m_ctr[k] = jp ? 3 : ((m_ctr[k] < 3) ? m_ctr[k] + 1 : 3);
            m_tgt[k] = tgt;
         end else begin
            m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
         end
      end else if (t) begin
         m_valid[k] = 1'b1;
         m_tag[k]   = pc >> ($clog2(ENT) + 2);
         m_tgt[k]   = tgt;
         m_ctr[k]   = jp ? 3 : 2;
      end
   endtask

   // Pop one expected lookup and compare all three outputs
   task automatic check_out();
      exp_t e;
      if (sb_q.size() == 0) begin
         chk("sb_underflow", 32'd1, 32'd0);
         return;
      end
      e = sb_q.pop_front();
      chk($sformatf("hit@%08h", e.pc),   {31'd0, pred_hit_o},   {31'd0, e.hit});
      chk($sformatf("taken@%08h", e.pc), {31'd0, pred_taken_o}, {31'd0, e.taken});
      chk($sformatf("next@%08h", e.pc),  pred_next_pc_o,        e.nxt);
   endtask

   // One cycle: drive lookup + optional update, check lookup before the edge, train model after
   task automatic step(input logic [31:0] pc, input logic upd, input logic [31:0] epc,
                       input logic tk, input logic jp, input logic [31:0] tgt);
      @(negedge clk);
      if_pc_i = pc; ex_update_i = upd; ex_pc_i = epc;
      ex_taken_i = tk; ex_is_jump_i = jp; ex_target_i = tgt;
      sb_q.push_back(m_look(pc));
      #2;
      check_out();
      @(posedge clk);
      if (upd) m_train(epc, tk, jp, tgt);
   endtask

   task automatic look(input logic [31:0] pc);
      step(pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      m_reset();
      // Reset held: nothing hits, next is sequential
      #3;
      chk("rst_hit",   {31'd0, pred_hit_o},   32'd0);
      chk("rst_taken", {31'd0, pred_taken_o}, 32'd0);
      chk("rst_next",  pred_next_pc_o,        32'h104);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < ENT; i++) look(32'(i * 4));
      look(32'hFFFF_FFFC);

      // Allocate at 0x100; same-cycle lookup sees the old (miss) state
      step(32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h80);
      look(32'h100);
      // Counter walk down: 10 -> 01 -> 00 -> 00
      for (int i = 0; i < 3; i++) step(32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'hDEAD);
      look(32'h100);
      // Walk back up: 00 -> 01 -> 10
      step(32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h80);
      look(32'h100);
      step(32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h88);
      look(32'h100);

      // Jump allocation (evicts alias at index 0), then one not-taken keeps predicting taken
      step(32'h200, 1'b1, 32'h200, 1'b1, 1'b1, 32'h400);
      look(32'h200);
      step(32'h200, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
      look(32'h200);
      look(32'h100);

      // Aliasing: 0x100 then 0x200 share an index
      step(32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h80);
      step(32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 32'h300);
      look(32'h100);
      look(32'h200);
      step(32'h200, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
      look(32'h200);

      // Other indices, including a jump flagged not-taken (still treated as taken)
      step(32'h10, 1'b1, 32'h10, 1'b1, 1'b0, 32'h1000);
      step(32'h10, 1'b1, 32'h24, 1'b0, 1'b1, 32'h2400);
      step(32'h24, 1'b1, 32'h3C, 1'b1, 1'b1, 32'h3C00);
      step(32'h3C, 1'b1, 32'h50, 1'b0, 1'b0, 32'h5000);
      look(32'h50);
      look(32'h13);
      look(32'hFFFF_FFFC);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] p;
         p = 32'h10 + 32'($urandom_range(0, 15) * 4);
         step(p, 1'b1, p, 1'($urandom_range(0, 1)), 1'b0, p + 32'h7000);
      end

      // Reset pulse of under one clock, covering an edge where an update is pending
      @(negedge clk);
      if_pc_i = 32'h10; ex_update_i = 1'b1; ex_pc_i = 32'h50;
      ex_taken_i = 1'b1; ex_is_jump_i = 1'b0; ex_target_i = 32'h999;
      #1 rst = 1'b1;
      m_reset();
      #1;
      chk("midrst_hit",   {31'd0, pred_hit_o},   32'd0);
      chk("midrst_taken", {31'd0, pred_taken_o}, 32'd0);
      chk("midrst_next",  pred_next_pc_o,        32'h14);
      #6;
      rst = 1'b0;
      ex_update_i = 1'b0;
      look(32'h50);
      look(32'h10);
      look(32'h24);
      look(32'h3C);
      look(32'h200);
      look(32'h100);
      // Table trains normally after reset
      step(32'h50, 1'b1, 32'h50, 1'b1, 1'b0, 32'h5555);
      look(32'h50);

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
